cache_req_ctrl: RTL and testbench

- Request controller directly upstream of the direct-mapped tag array.
- Accepts read/write/invalidate requests on a 32-bit address and splits the address into tag, set and byte offset.
- Reads the tag array, compares tags, handles misses (dirty writeback, then line fill from next-level memory) and writes valid/dirty/tag back.
- Returns one response per accepted request.

---
 rtl/cache_req_ctrl_if.sv | 22 ++
 rtl/cache_req_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cache_req_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_req_ctrl_if.sv
// Request/response handshake between a requester and cache_req_ctrl.
// A request transfers when req_valid && req_ready at a rising edge; rsp_valid is a one-cycle pulse.
interface cache_req_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_hit;

    modport master (
        output req_valid, req_op, req_addr,
        input  req_ready, rsp_valid, rsp_hit
    );

    modport slave (
        input  req_valid, req_op, req_addr,
        output req_ready, rsp_valid, rsp_hit
    );
endinterface

// File: rtl/cache_req_ctrl.sv
// Request controller in front of a direct-mapped tag array: lookup, writeback, fill, tag update.
// Optional saturating statistics counters are enabled by defining CACHE_REQ_STATS_EN.
module cache_req_ctrl #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 11,
    parameter int SET_W  = 15,
    parameter int OFF_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_req_ctrl_if.slave   req_if,
    output logic [SET_W-1:0]  ta_set,
    output logic              ta_we,
    output logic              ta_valid_wr,
    output logic              ta_dirty_wr,
    output logic [TAG_W-1:0]  ta_tag_wr,
    input  logic              ta_valid,
    input  logic              ta_dirty,
    input  logic [TAG_W-1:0]  ta_tag,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_wbs,
    output logic [2:0]        state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WRBACK = 3'd2,
        S_FILL   = 3'd3,
        S_UPDATE = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t            state, next_state;
    logic [1:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [SET_W-1:0]  set_q;
    logic              hit_q;
    logic              old_dirty_q;
    logic [TAG_W-1:0]  old_tag_q;

    logic accept, lookup_hit, is_wr, is_inv;
    logic unused_off;

    assign accept     = (state == S_IDLE) && req_if.req_valid;
    assign lookup_hit = ta_valid && (ta_tag == tag_q);
    assign is_wr      = (op_q == 2'b01);
    assign is_inv     = (op_q == 2'b10);
    assign unused_off = &{1'b0, req_if.req_addr[OFF_W-1:0]};
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= 2'b00;
            tag_q       <= '0;
            set_q       <= '0;
            hit_q       <= 1'b0;
            old_dirty_q <= 1'b0;
            old_tag_q   <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q  <= req_if.req_op;
                tag_q <= req_if.req_addr[ADDR_W-1 -: TAG_W];
                set_q <= req_if.req_addr[OFF_W +: SET_W];
            end
            // Victim state is captured once; WRBACK and UPDATE use the snapshot.
            if (state == S_LOOKUP) begin
                hit_q       <= lookup_hit;
                old_dirty_q <= ta_dirty;
                old_tag_q   <= ta_tag;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = S_LOOKUP;
            S_LOOKUP: begin
                if (is_inv) begin
                    if (!lookup_hit)   next_state = S_RESP;
                    else if (ta_dirty) next_state = S_WRBACK;
                    else               next_state = S_UPDATE;
                end else begin
                    if (lookup_hit)                next_state = S_UPDATE;
                    else if (ta_valid && ta_dirty) next_state = S_WRBACK;
                    else                           next_state = S_FILL;
                end
            end
            S_WRBACK: if (mem_ack) next_state = is_inv ? S_UPDATE : S_FILL;
            S_FILL:   if (mem_ack) next_state = S_UPDATE;
            S_UPDATE: next_state = S_RESP;
            S_RESP:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_if.req_ready  = (state == S_IDLE);
        req_if.rsp_valid  = 1'b0;
        req_if.rsp_hit    = 1'b0;
        ta_set            = set_q;
        ta_we             = 1'b0;
        ta_valid_wr       = 1'b0;
        ta_dirty_wr       = 1'b0;
        ta_tag_wr         = '0;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = '0;
        case (state)
            S_WRBACK: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {old_tag_q, set_q, {OFF_W{1'b0}}};
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, set_q, {OFF_W{1'b0}}};
            end
            S_UPDATE: begin
                ta_we = 1'b1;
                if (is_inv) begin
                    ta_tag_wr = old_tag_q;
                end else begin
                    ta_valid_wr = 1'b1;
                    ta_tag_wr   = tag_q;
                    // A read keeps the line's dirty bit on a hit; a fresh fill is clean.
                    ta_dirty_wr = is_wr ? 1'b1 : (hit_q && old_dirty_q);
                end
            end
            S_RESP: begin
                req_if.rsp_valid = 1'b1;
                req_if.rsp_hit   = hit_q;
            end
            default: ;
        endcase
    end

`ifdef CACHE_REQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbs    <= '0;
        end else begin
            if (state == S_LOOKUP && lookup_hit && stat_hits != '1)
                stat_hits <= stat_hits + 32'd1;
            if (state == S_LOOKUP && !lookup_hit && !is_inv && stat_misses != '1)
                stat_misses <= stat_misses + 32'd1;
            if (state == S_WRBACK && mem_ack && stat_wbs != '1)
                stat_wbs <= stat_wbs + 32'd1;
        end
    end
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
    assign stat_wbs    = '0;
`endif
endmodule

// File: tb/tb_cache_req_ctrl.sv
// Bench for cache_req_ctrl: a behavioural tag array, a vector table of requests with
// expected memory traffic, tag writes and latency, and hand-written reset/stray-ack sequences.
module tb_cache_req_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cache_req_ctrl_if #(.ADDR_W(32)) rif ();

  logic [14:0] ta_set;
  logic        ta_we, ta_valid_wr, ta_dirty_wr;
  logic [10:0] ta_tag_wr;
  logic        ta_valid, ta_dirty;
  logic [10:0] ta_tag;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] stat_hits, stat_misses, stat_wbs;
  logic [2:0]  state_dbg;

  cache_req_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_if(rif),
    .ta_set(ta_set), .ta_we(ta_we), .ta_valid_wr(ta_valid_wr), .ta_dirty_wr(ta_dirty_wr),
    .ta_tag_wr(ta_tag_wr), .ta_valid(ta_valid), .ta_dirty(ta_dirty), .ta_tag(ta_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // tag array model: combinational read, write on the rising edge
  logic        mv [0:32767] = '{default: 1'b0};
  logic        md [0:32767] = '{default: 1'b0};
  logic [10:0] mt [0:32767] = '{default: 11'h0};
  assign ta_valid = mv[ta_set];
  assign ta_dirty = md[ta_set];
  assign ta_tag   = mt[ta_set];
  always @(posedge clk) begin
    if (ta_we) begin
      mv[ta_set] <= ta_valid_wr;
      md[ta_set] <= ta_dirty_wr;
      mt[ta_set] <= ta_tag_wr;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    int          delay;
    logic        hit;
    logic        wb;
    logic [31:0] wb_addr;
    logic        fill;
    logic [31:0] fill_addr;
    logic        twe;
    logic        tv;
    logic        td;
    logic [10:0] ttag;
    logic [14:0] tset;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  // driver + monitor for one request; called and returns at a falling edge
  task automatic run_vec(input int i);
    vec_t v;
    int cyc, hold, nx, nwe, cur;
    bit got;
    logic exp_we_now;
    logic [31:0] exp_a_now;
    logic [0:0] e;
    v = vecs[i];
    cyc = 0; hold = 0; nx = 0; nwe = 0; got = 0;
    check($sformatf("v%0d req_ready", i), 32'(rif.req_ready), 32'd1);
    rif.req_valid = 1'b1;
    rif.req_op    = v.op;
    rif.req_addr  = v.addr;
    @(negedge clk);
    rif.req_valid = 1'b0;
    exp_q.push_back(v.hit);
    while (!got && cyc < 200) begin
      if (rif.rsp_valid) begin
        got = 1;
        check($sformatf("v%0d latency", i), 32'(cyc + 1), 32'(v.lat));
        e = exp_q.pop_front();
        check($sformatf("v%0d rsp_hit", i), 32'(rif.rsp_hit), 32'(e));
      end
      if (ta_we) begin
        nwe++;
        check($sformatf("v%0d ta_set", i), 32'(ta_set), 32'(v.tset));
        check($sformatf("v%0d ta_valid_wr", i), 32'(ta_valid_wr), 32'(v.tv));
        check($sformatf("v%0d ta_dirty_wr", i), 32'(ta_dirty_wr), 32'(v.td));
        check($sformatf("v%0d ta_tag_wr", i), 32'(ta_tag_wr), 32'(v.ttag));
      end
      if (mem_req) begin
        if (hold == 0) nx++;
        cur = nx - 1;
        exp_we_now = v.wb && (cur == 0);
        exp_a_now  = exp_we_now ? v.wb_addr : v.fill_addr;
        check($sformatf("v%0d x%0d mem_we", i, cur), 32'(mem_we), 32'(exp_we_now));
        check($sformatf("v%0d x%0d mem_addr", i, cur), mem_addr, exp_a_now);
        hold++;
        if (hold > v.delay) begin
          mem_ack = 1'b1;
          hold = 0;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
        hold = 0;
      end
      if (!got) begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;
    if (!got) begin
      check($sformatf("v%0d rsp timeout", i), 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    check($sformatf("v%0d transfers", i), 32'(nx), 32'(int'(v.wb) + int'(v.fill)));
    check($sformatf("v%0d tag writes", i), 32'(nwe), 32'(v.twe));
  endtask

  initial begin
    int n;
    rif.req_valid = 1'b0;
    rif.req_op    = 2'b00;
    rif.req_addr  = 32'h0;

    //                 op     addr          dly hit wb  wb_addr      fill fill_addr   twe v  d  tag     set       lat
    vecs[0] = '{2'b00, 32'h0000_0040, 0, 0, 0, 32'h0,        1, 32'h0000_0040, 1, 1, 0, 11'h000, 15'h0001, 4};
    vecs[1] = '{2'b01, 32'h0000_0040, 0, 1, 0, 32'h0,        0, 32'h0,         1, 1, 1, 11'h000, 15'h0001, 3};
    vecs[2] = '{2'b00, 32'h0020_0040, 2, 0, 1, 32'h0000_0040, 1, 32'h0020_0040, 1, 1, 0, 11'h001, 15'h0001, 9};
    vecs[3] = '{2'b10, 32'h0020_0040, 0, 1, 0, 32'h0,        0, 32'h0,         1, 0, 0, 11'h001, 15'h0001, 3};
    vecs[4] = '{2'b10, 32'h0020_0040, 0, 0, 0, 32'h0,        0, 32'h0,         0, 0, 0, 11'h000, 15'h0000, 2};
    vecs[5] = '{2'b01, 32'h1234_5678, 1, 0, 0, 32'h0,        1, 32'h1234_5640, 1, 1, 1, 11'h091, 15'h5159, 5};
    vecs[6] = '{2'b10, 32'h1234_5678, 0, 1, 1, 32'h1234_5640, 0, 32'h0,         1, 0, 0, 11'h091, 15'h5159, 4};
    vecs[7] = '{2'b11, 32'h1234_5678, 10, 0, 0, 32'h0,       1, 32'h1234_5640, 1, 1, 0, 11'h091, 15'h5159, 14};
    vecs[8] = '{2'b00, 32'h1234_5678, 0, 1, 0, 32'h0,        0, 32'h0,         1, 1, 0, 11'h091, 15'h5159, 3};
    vecs[9] = '{2'b00, 32'h0000_0080, 0, 0, 0, 32'h0,        1, 32'h0000_0080, 1, 1, 0, 11'h000, 15'h0002, 4};

    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(rif.req_ready), 32'd1);
    check("reset rsp_valid", 32'(rif.rsp_valid), 32'd0);
    check("reset rsp_hit", 32'(rif.rsp_hit), 32'd0);
    check("reset ta_we", 32'(ta_we), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset ta_set", 32'(ta_set), 32'd0);
    check("reset stat_hits", stat_hits, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      run_vec(i);
    end

`ifdef CACHE_REQ_STATS_EN
    check("stat_hits", stat_hits, 32'd4);
    check("stat_misses", stat_misses, 32'd4);
    check("stat_wbs", stat_wbs, 32'd2);
`else
    check("stat_hits", stat_hits, 32'd0);
    check("stat_misses", stat_misses, 32'd0);
    check("stat_wbs", stat_wbs, 32'd0);
`endif

    // stray mem_ack while idle
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray ack state", 32'(state_dbg), 32'd0);
    check("stray ack mem_req", 32'(mem_req), 32'd0);
    check("stray ack rsp_valid", 32'(rif.rsp_valid), 32'd0);
    check("stray ack req_ready", 32'(rif.req_ready), 32'd1);

    // reset asserted during FILL with mem_ack withheld
    rif.req_valid = 1'b1;
    rif.req_op    = 2'b00;
    rif.req_addr  = 32'h0000_0080;
    @(negedge clk);
    rif.req_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("abort reached fill", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort mem_req", 32'(mem_req), 32'd0);
    check("abort req_ready", 32'(rif.req_ready), 32'd1);
    check("abort ta_we", 32'(ta_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("abort no rsp %0d", k), 32'(rif.rsp_valid), 32'd0);
      check($sformatf("abort no ta_we %0d", k), 32'(ta_we), 32'd0);
    end
    check("abort set2 untouched", 32'(mv[2]), 32'd0);
    check("abort stats cleared", stat_wbs, 32'd0);

    run_vec(9);
`ifdef CACHE_REQ_STATS_EN
    check("post stat_misses", stat_misses, 32'd1);
`else
    check("post stat_misses", stat_misses, 32'd0);
`endif
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
